// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the I2C bus arbiter.
// Latency: none, wires only.
// Backpressure: carries the controller i_ready/o_ready handshakes to and from the owner.
interface i2c_bus_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int MODE_W = 2
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ*MODE_W-1:0] r_mode;
  logic [N_REQ-1:0]        r_i_valid;
  logic [N_REQ*7-1:0]      r_i_addr;
  logic [N_REQ*8-1:0]      r_i_data;
  logic [N_REQ-1:0]        r_i_ready;
  logic [N_REQ-1:0]        r_o_ready;
  logic [N_REQ-1:0]        r_o_valid;
  logic [7:0]              r_o_data;
  logic [MODE_W-1:0]       c_mode;
  logic                    c_i_valid;
  logic [6:0]              c_i_addr;
  logic [7:0]              c_i_data;
  logic                    c_i_ready;
  logic                    c_o_ready;
  logic                    c_o_valid;
  logic [7:0]              c_o_data;
  logic                    timeout;
  logic                    busy;

  // Arbiter side
  modport slave (
    input  req, r_mode, r_i_valid, r_i_addr, r_i_data, r_o_ready,
           c_i_ready, c_o_valid, c_o_data,
    output gnt, r_i_ready, r_o_valid, r_o_data,
           c_mode, c_i_valid, c_i_addr, c_i_data, c_o_ready, timeout, busy
  );

  // Requesters plus controller side
  modport master (
    output req, r_mode, r_i_valid, r_i_addr, r_i_data, r_o_ready,
           c_i_ready, c_o_valid, c_o_data,
    input  gnt, r_i_ready, r_o_valid, r_o_data,
           c_mode, c_i_valid, c_i_addr, c_i_data, c_o_ready, timeout, busy
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter with bus lock sharing one i2c_controller between N_REQ requesters.
// Latency: grant 1 cycle after req is sampled; owner<->controller path is combinational.
// Backpressure: controller i_ready gates grant/release; abandoned or reclaimed bus drains until i_ready.
module i2c_bus_arbiter #(
  parameter int N_REQ          = 2,
  parameter int MODE_W         = 2,
  parameter int TIMEOUT_CYCLES = 1_200_000
) (
  input logic              clk,
  input logic              rst,
  i2c_bus_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] last_owner, last_owner_nxt;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_fire;
  logic [N_REQ-1:0] gnt_q;
  logic             timeout_q, timeout_nxt;

  assign wd_fire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);

  // Round-robin pick: first requesting bit above last_owner, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_vld && bus.req[(int'(last_owner) + k) % N_REQ]) begin
        pick     = IDX_W'((int'(last_owner) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state: grant when controller is idle, release/abandon/reclaim from ownership
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    timeout_nxt    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pick_vld && bus.c_i_ready) begin
          owner_nxt = pick;
          state_nxt = S_OWN;
        end
      end
      S_OWN: begin
        // Watchdog wins over a release in the same cycle
        if (wd_fire) begin
          timeout_nxt    = 1'b1;
          last_owner_nxt = owner;
          state_nxt      = S_DRAIN;
        end else if (!bus.req[owner]) begin
          // Abandon also rotates priority so other pending requesters go first
          last_owner_nxt = owner;
          state_nxt      = bus.c_i_ready ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.c_i_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, owner, registered grant/timeout and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      gnt_q      <= '0;
      timeout_q  <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      timeout_q  <= timeout_nxt;
      gnt_q      <= '0;
      if (state_nxt == S_OWN) gnt_q[owner_nxt] <= 1'b1;
      // Counter is zero in the first owned cycle
      wd_cnt     <= (state == S_OWN) ? wd_cnt + 1'b1 : '0;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.r_o_data = bus.c_o_data;

  // Owner mux; drain keeps o_ready high so stale read data is swallowed
  always_comb begin
    bus.c_mode    = '0;
    bus.c_i_valid = 1'b0;
    bus.c_i_addr  = '0;
    bus.c_i_data  = '0;
    bus.c_o_ready = 1'b0;
    bus.r_i_ready = '0;
    bus.r_o_valid = '0;
    case (state)
      S_OWN: begin
        bus.c_mode            = bus.r_mode[int'(owner)*MODE_W +: MODE_W];
        bus.c_i_valid         = bus.r_i_valid[owner];
        bus.c_i_addr          = bus.r_i_addr[int'(owner)*7 +: 7];
        bus.c_i_data          = bus.r_i_data[int'(owner)*8 +: 8];
        bus.c_o_ready         = bus.r_o_ready[owner];
        bus.r_i_ready[owner]  = bus.c_i_ready;
        bus.r_o_valid[owner]  = bus.c_o_valid;
      end
      S_DRAIN: bus.c_o_ready = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency: model predicts outputs every cycle, compared mid-cycle on the falling edge.
// Backpressure: controller i_ready and requester o_ready are randomized.
module tb_i2c_bus_arbiter;
  localparam int N  = 3;
  localparam int MW = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: owner index or -1, draining flag, rotation pointer
  int m_own, m_last, m_held;
  bit m_drain, m_to;

  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.N_REQ(N), .MODE_W(MW)) bus ();

  i2c_bus_arbiter #(.N_REQ(N), .MODE_W(MW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (rst) begin
      m_own = -1; m_drain = 1'b0; m_last = N - 1; m_held = 0;
    end else if (m_own >= 0) begin
      if (TO != 0 && m_held + 1 == TO) begin
        m_last = m_own; m_own = -1; m_drain = 1'b1; m_to = 1'b1;
      end else if (!bus.req[m_own]) begin
        m_last = m_own; m_own = -1; m_drain = !bus.c_i_ready;
      end else begin
        m_held++;
      end
    end else if (m_drain) begin
      if (bus.c_i_ready) m_drain = 1'b0;
    end else if (bus.c_i_ready) begin
      for (int k = 1; k <= N; k++) begin
        if (m_own < 0 && bus.req[(m_last + k) % N]) begin
          m_own  = (m_last + k) % N;
          m_held = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_gnt, e_rir, e_rov;
    logic         e_civ, e_cor;
    logic [31:0]  e_mode, e_addr, e_data;
    e_gnt = '0; e_rir = '0; e_rov = '0;
    e_civ = 1'b0; e_cor = m_drain; e_mode = 0; e_addr = 0; e_data = 0;
    if (m_own >= 0) begin
      e_gnt[m_own] = 1'b1;
      e_rir[m_own] = bus.c_i_ready;
      e_rov[m_own] = bus.c_o_valid;
      e_civ  = bus.r_i_valid[m_own];
      e_cor  = bus.r_o_ready[m_own];
      e_mode = 32'(bus.r_mode >> (MW * m_own)) & ((32'd1 << MW) - 1);
      e_addr = 32'(bus.r_i_addr >> (7 * m_own)) & 32'h7f;
      e_data = 32'(bus.r_i_data >> (8 * m_own)) & 32'hff;
    end
    check("gnt",       32'(bus.gnt),       32'(e_gnt));
    check("busy",      32'(bus.busy),      32'(m_own >= 0 || m_drain));
    check("timeout",   32'(bus.timeout),   32'(m_to));
    check("c_i_valid", 32'(bus.c_i_valid), 32'(e_civ));
    check("c_o_ready", 32'(bus.c_o_ready), 32'(e_cor));
    check("c_mode",    32'(bus.c_mode),    e_mode);
    check("c_i_addr",  32'(bus.c_i_addr),  e_addr);
    check("c_i_data",  32'(bus.c_i_data),  e_data);
    check("r_i_ready", 32'(bus.r_i_ready), 32'(e_rir));
    check("r_o_valid", 32'(bus.r_o_valid), 32'(e_rov));
    check("r_o_data",  32'(bus.r_o_data),  32'(bus.c_o_data));
  endtask

  // One clock: compare mid-cycle, advance model on the edge, return just after it
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.r_mode = '0; bus.r_i_valid = '0; bus.r_i_addr = '0;
    bus.r_i_data = '0; bus.r_o_ready = '0; bus.c_i_ready = 1'b1;
    bus.c_o_valid = 1'b0; bus.c_o_data = '0;
    @(posedge clk);
    model_step();
    #1;
    cycle();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single requester with address/data passthrough
    rst = 1'b0;
    bus.req = 3'b001; bus.r_i_valid = 3'b001;
    bus.r_i_addr = 21'h38; bus.r_i_data = 24'h80;
    cycle();
    check("single_gnt", 32'(bus.gnt), 32'h1);
    check("single_addr", 32'(bus.c_i_addr), 32'h38);
    check("single_data", 32'(bus.c_i_data), 32'h80);
    bus.req = 3'b000;
    cycle();
    check("release_gnt", 32'(bus.gnt), 32'h0);
    check("release_busy", 32'(bus.busy), 32'h0);

    // Simultaneous requests from reset, gap between owners, rotation back
    rst = 1'b1; cycle(); rst = 1'b0;
    bus.req = 3'b011; bus.r_i_valid = '0;
    cycle(); check("tie_first", 32'(bus.gnt), 32'h1);
    bus.req = 3'b010;
    cycle(); check("tie_gap", 32'(bus.gnt), 32'h0);
    cycle(); check("tie_second", 32'(bus.gnt), 32'h2);
    bus.req = 3'b001;
    cycle(); check("tie_gap2", 32'(bus.gnt), 32'h0);
    cycle(); check("tie_back", 32'(bus.gnt), 32'h1);

    // Isolation while requester 1 owns the bus
    rst = 1'b1; cycle(); rst = 1'b0;
    bus.req = 3'b010;
    cycle(); check("iso_gnt", 32'(bus.gnt), 32'h2);
    bus.c_o_valid = 1'b1; bus.c_o_data = 8'h5A; bus.r_i_valid = 3'b001;
    #1;
    check("iso_r_o_valid", 32'(bus.r_o_valid), 32'h2);
    check("iso_r_o_data", 32'(bus.r_o_data), 32'h5A);
    check("iso_c_i_valid", 32'(bus.c_i_valid), 32'h0);
    check("iso_r_i_ready", 32'(bus.r_i_ready), 32'h2);

    // Abandon mid-transaction, drain for 20 cycles, then 2-cycle regrant
    bus.c_o_valid = 1'b0; bus.r_o_ready = '0;
    bus.req = 3'b001; bus.c_i_ready = 1'b0;
    cycle();
    check("drain_gnt", 32'(bus.gnt), 32'h0);
    check("drain_busy", 32'(bus.busy), 32'h1);
    check("drain_o_ready", 32'(bus.c_o_ready), 32'h1);
    repeat (19) cycle();
    bus.c_i_ready = 1'b1;
    cycle(); check("drain_idle", 32'(bus.gnt), 32'h0);
    cycle(); check("drain_regrant", 32'(bus.gnt), 32'h1);

    // Watchdog: owner 0 holds req, requester 1 waits
    bus.req = 3'b011;
    repeat (15) cycle();
    check("wd_hold_gnt", 32'(bus.gnt), 32'h1);
    check("wd_hold_to", 32'(bus.timeout), 32'h0);
    cycle();
    check("wd_timeout", 32'(bus.timeout), 32'h1);
    check("wd_gnt_drop", 32'(bus.gnt), 32'h0);
    cycle(); check("wd_pulse_end", 32'(bus.timeout), 32'h0);
    cycle(); check("wd_next_owner", 32'(bus.gnt), 32'h2);

    // Reset while requester 1 owns
    rst = 1'b1;
    cycle();
    check("rst_mid_gnt", 32'(bus.gnt), 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    check("rst_mid_to", 32'(bus.timeout), 32'h0);
    rst = 1'b0; bus.req = 3'b011;
    cycle(); check("rst_mid_tie", 32'(bus.gnt), 32'h1);

    // Randomized traffic with sticky requests
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) bus.req[b] = ~bus.req[b];
      bus.c_i_ready = ($urandom_range(0, 3) != 0);
      bus.r_mode    = (N*MW)'($urandom);
      bus.r_i_valid = N'($urandom);
      bus.r_i_addr  = (N*7)'($urandom);
      bus.r_i_data  = (N*8)'($urandom);
      bus.r_o_ready = N'($urandom);
      bus.c_o_valid = 1'($urandom);
      bus.c_o_data  = 8'($urandom);
      rst           = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one i2c_controller instance between N_REQ requesting masters, e.g. the FT6206 touch controller and a second on-board I2C sensor/config block.
- Round-robin arbitration with bus lock: a granted requester owns the controller for a whole multi-transaction sequence (register-pointer write, then read) until it drops req.
- Sits between the requesters and i2c_controller, and muxes mode/valid/addr/data in both directions.
- A watchdog forcibly reclaims the bus from a requester that holds it too long.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- MODE_W, 2, width of the i2c_transaction_t mode field.
- TIMEOUT_CYCLES, 1_200_000, maximum cycles one requester may own the bus; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester bus request, held for the whole sequence
- gnt  out  N_REQ  one-hot grant, registered
- r_mode  in  N_REQ*MODE_W  per-requester transaction mode, slice i = requester i
- r_i_valid  in  N_REQ  per-requester command valid
- r_i_addr  in  N_REQ*7  per-requester 7-bit device address
- r_i_data  in  N_REQ*8  per-requester write data
- r_i_ready  out  N_REQ  controller i_ready routed to the owner; 0 for others
- r_o_ready  in  N_REQ  per-requester read-data ready
- r_o_valid  out  N_REQ  controller o_valid routed to the owner; 0 for others
- r_o_data  out  8  controller o_data broadcast; meaningful only with r_o_valid
- c_mode  out  MODE_W  to controller mode
- c_i_valid  out  1  to controller i_valid
- c_i_addr  out  7  to controller i_addr
- c_i_data  out  8  to controller i_data
- c_i_ready  in  1  from controller i_ready
- c_o_ready  out  1  to controller o_ready
- c_o_valid  in  1  from controller o_valid
- timeout  out  1  one-cycle pulse when the watchdog reclaims the bus
- busy  out  1  high while not in S_IDLE

Behaviour:
- Reset values:
  - state = S_IDLE; gnt = 0; owner = 0; last_owner = N_REQ-1, so req[0] wins the first tie.
  - timeout = 0; busy = 0; watchdog counter = 0.
- S_IDLE:
  - gnt = 0. All c_* outputs are driven 0 (c_mode = 0); c_i_valid is always 0 here.
  - If |req and c_i_ready: owner = first set req bit searching upward from last_owner+1, modulo N_REQ. Go to S_OWN.
  - gnt[owner] goes high on the next cycle, so grant latency is 1 cycle from req sampled.
  - If c_i_ready is low, stay in S_IDLE.
- S_OWN:
  - gnt = onehot(owner).
  - c_mode, c_i_valid, c_i_addr, c_i_data and c_o_ready = owner's slices.
  - r_i_ready[owner] = c_i_ready and r_o_valid[owner] = c_o_valid. All other bits are 0.
  - Mux is combinational from the registered owner, so the owner↔controller path adds zero latency.
  - If req[owner] = 0 and c_i_ready = 1: last_owner = owner, go to S_IDLE.
  - If req[owner] = 0 and c_i_ready = 0: go to S_DRAIN (owner abandoned mid-transaction).
  - Watchdog counter increments each S_OWN cycle.
  - If TIMEOUT_CYCLES ≠ 0 and counter = TIMEOUT_CYCLES-1: pulse timeout for 1 cycle, last_owner = owner, go to S_DRAIN. Watchdog has priority over release in the same cycle.
- S_DRAIN:
  - gnt = 0; c_i_valid = 0; c_o_ready = 1, so in-flight read data is discarded; all r_i_ready and r_o_valid = 0.
  - Wait for c_i_ready = 1, then go to S_IDLE.
- Watchdog counter clears on every entry to S_OWN. Width = clog2(TIMEOUT_CYCLES+1).
- Released bus:
  - gnt is low for at least 1 cycle between consecutive owners.
  - A requester still holding req after release competes again.
  - Round-robin guarantees any other pending requester is served first.
- A requester whose req is low when its grant would be issued is skipped; the grant is never given to a non-requesting bit.
- A req change on a non-owner during S_OWN has no effect until S_IDLE.
- Owner's r_i_valid while c_i_ready = 0 passes through unchanged. The controller ignores it; the arbiter does not buffer.
- rst mid-transaction returns to the reset state immediately. The controller is reset by the same rst.
- Invariants:
  - gnt is one-hot or zero.
  - c_i_valid = 0 whenever gnt = 0.

Test Plan:
- Single requester: req = 2'b01 with c_i_ready = 1 → gnt = 2'b01 one cycle later. r_i_addr slice 0 = 7'h38, data 8'h80 appear on c_i_addr/c_i_data. Drop req with c_i_ready = 1 → gnt = 0 next cycle, busy = 0.
- Simultaneous req = 2'b11 from reset → gnt = 01 first. After release, gnt = 10 after a 1-cycle gnt = 0 gap. Then gnt = 01 again if req[0] is still held.
- Isolation: requester 1 owns the bus and c_o_valid = 1 with c_o_data = 8'h5A → r_o_valid = 2'b10. Requester 0's r_i_valid = 1 never reaches c_i_valid.
- Abandon mid-transaction: owner drops req while c_i_ready = 0 → S_DRAIN with gnt = 0 and c_o_ready = 1. After c_i_ready rises 20 cycles later, the next grant issues 2 cycles after that (S_DRAIN→S_IDLE, S_IDLE→S_OWN, grant registered on entering S_OWN).
- Watchdog with TIMEOUT_CYCLES = 16: owner holds req indefinitely → timeout pulses at the 16th S_OWN cycle and gnt drops. The other pending requester is granted once c_i_ready = 1.
- Reset mid-grant: assert rst while gnt = 10 → next cycle gnt = 0, busy = 0, timeout = 0. With req = 11 after reset, requester 0 wins.
